// File: rtl/pointwise_conv_tmux.sv
// -----------------------------------------------------------------------------
// pointwise_conv_tmux
//   Time-multiplexed pointwise (1x1) convolution stage. One input pixel of
//   IN_CH signed fixed-point channels is mapped to OUT_CH output channels by
//   OUT_CH parallel MACs that walk through the input channels one per cycle.
//   Weights live in a runtime-loadable register array.
//
//   Optional feature (macro PWCONV_RELU_EN): when defined, negative
//   saturated results are clamped to zero before they reach Data_Out.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   Data_In    input pixel, channel k at [k*DATA_WIDHT +: DATA_WIDHT]
//   Valid_In   Data_In valid
//   Ready_In   block accepts Data_In this cycle
//   Data_Out   result pixel, channel o at [o*DATA_WIDHT +: DATA_WIDHT]
//   Valid_Out  Data_Out valid (held until Ready_Out)
//   Ready_Out  downstream accepts Data_Out
//   W_We       weight write strobe (honoured in IDLE only)
//   W_Addr     weight index o*IN_CH + i
//   W_Data     signed weight value
// -----------------------------------------------------------------------------
module pointwise_conv_tmux #(
    parameter int DATA_WIDHT = 16,
    parameter int FRAC_BITS  = 8,
    parameter int IN_CH      = 32,
    parameter int OUT_CH     = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDHT*IN_CH-1:0]      Data_In,
    input  logic                             Valid_In,
    output logic                             Ready_In,
    output logic [DATA_WIDHT*OUT_CH-1:0]     Data_Out,
    output logic                             Valid_Out,
    input  logic                             Ready_Out,
    input  logic                             W_We,
    input  logic [$clog2(IN_CH*OUT_CH)-1:0]  W_Addr,
    input  logic [DATA_WIDHT-1:0]            W_Data
);
    localparam int NW    = IN_CH * OUT_CH;
    localparam int AW    = $clog2(NW);
    localparam int CW    = $clog2(IN_CH);
    localparam int PW    = 2 * DATA_WIDHT;
    localparam int ACC_W = PW + CW;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_WIDHT+1){1'b0}}, {(DATA_WIDHT-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_WIDHT+1){1'b1}}, {(DATA_WIDHT-1){1'b0}}};
    localparam logic [DATA_WIDHT-1:0] SAT_MAX_W = {1'b0, {(DATA_WIDHT-1){1'b1}}};
    localparam logic [DATA_WIDHT-1:0] SAT_MIN_W = {1'b1, {(DATA_WIDHT-1){1'b0}}};
    localparam logic [CW-1:0] CNT_LAST = CW'(IN_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                        state_q;
    logic [CW-1:0]                 cnt_q;
    logic [DATA_WIDHT*IN_CH-1:0]   x_q;
    logic signed [ACC_W-1:0]       acc_q [OUT_CH];
    logic signed [DATA_WIDHT-1:0]  w_q [NW];
    logic [DATA_WIDHT*OUT_CH-1:0]  data_out_q;
    logic                          valid_out_q;

    // A weight overwritten in the same IDLE cycle that a pixel is accepted
    // must not affect that pixel: its previous value is kept here and used
    // in place of the array entry for the remainder of that computation.
    logic                          ovr_vld_q;
    logic [AW-1:0]                 ovr_addr_q;
    logic signed [DATA_WIDHT-1:0]  ovr_val_q;

    logic signed [DATA_WIDHT-1:0]  x_arr_s [IN_CH];
    logic signed [DATA_WIDHT-1:0]  x_cur_s;
    logic [AW-1:0]                 widx_s;
    logic signed [DATA_WIDHT-1:0]  w_cur_s;
    logic signed [PW-1:0]          prod_s;
    logic signed [PW-1:0]          prod_sh_s;
    logic [DATA_WIDHT-1:0]         sat_s;
    logic signed [ACC_W-1:0]       acc_d [OUT_CH];
    logic [DATA_WIDHT*OUT_CH-1:0]  res_d;
    logic                          w_addr_ok_s;

    // Address range check; folds away when the array fills the address space.
    generate
        if (NW == (2 ** AW)) begin : g_addr_full
            assign w_addr_ok_s = 1'b1;
        end else begin : g_addr_part
            assign w_addr_ok_s = (W_Addr < AW'(NW));
        end
    endgenerate

    // MAC step for the current input channel plus saturation of the running sums.
    always_comb begin
        w_cur_s   = '0;
        prod_s    = '0;
        prod_sh_s = '0;
        sat_s     = '0;
        widx_s    = '0;
        res_d     = '0;
        for (int k = 0; k < IN_CH; k++) begin
            x_arr_s[k] = $signed(x_q[k*DATA_WIDHT +: DATA_WIDHT]);
        end
        x_cur_s = x_arr_s[cnt_q];
        for (int o = 0; o < OUT_CH; o++) begin
            widx_s = AW'(o * IN_CH) + AW'(cnt_q);
            if (ovr_vld_q && (ovr_addr_q == widx_s)) begin
                w_cur_s = ovr_val_q;
            end else begin
                w_cur_s = w_q[widx_s];
            end
            prod_s    = x_cur_s * w_cur_s;
            prod_sh_s = prod_s >>> FRAC_BITS;
            acc_d[o]  = acc_q[o] + {{CW{prod_sh_s[PW-1]}}, prod_sh_s};
            if (acc_d[o] > SAT_MAX) begin
                sat_s = SAT_MAX_W;
            end else if (acc_d[o] < SAT_MIN) begin
                sat_s = SAT_MIN_W;
            end else begin
                sat_s = acc_d[o][DATA_WIDHT-1:0];
            end
`ifdef PWCONV_RELU_EN
            sat_s = sat_s[DATA_WIDHT-1] ? '0 : sat_s;
`endif
            res_d[o*DATA_WIDHT +: DATA_WIDHT] = sat_s;
        end
    end

    // Input handshake: free in IDLE, pass-through of downstream ready in HOLD.
    always_comb begin
        case (state_q)
            S_IDLE:  Ready_In = 1'b1;
            S_HOLD:  Ready_In = Ready_Out;
            default: Ready_In = 1'b0;
        endcase
    end

    // Control FSM, datapath registers and weight store.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            ovr_vld_q   <= 1'b0;
            ovr_addr_q  <= '0;
            ovr_val_q   <= '0;
            for (int o = 0; o < OUT_CH; o++) begin
                acc_q[o] <= '0;
            end
            for (int n = 0; n < NW; n++) begin
                w_q[n] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (W_We && w_addr_ok_s) begin
                        w_q[W_Addr] <= W_Data;
                    end
                    if (Valid_In) begin
                        x_q        <= Data_In;
                        cnt_q      <= '0;
                        ovr_vld_q  <= W_We && w_addr_ok_s;
                        ovr_addr_q <= W_Addr;
                        ovr_val_q  <= w_q[W_Addr];
                        for (int o = 0; o < OUT_CH; o++) begin
                            acc_q[o] <= '0;
                        end
                        state_q <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    for (int o = 0; o < OUT_CH; o++) begin
                        acc_q[o] <= acc_d[o];
                    end
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        data_out_q  <= res_d;
                        valid_out_q <= 1'b1;
                        ovr_vld_q   <= 1'b0;
                        state_q     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (Ready_Out) begin
                        valid_out_q <= 1'b0;
                        if (Valid_In) begin
                            x_q       <= Data_In;
                            cnt_q     <= '0;
                            ovr_vld_q <= 1'b0;
                            for (int o = 0; o < OUT_CH; o++) begin
                                acc_q[o] <= '0;
                            end
                            state_q <= S_ACCUM;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Data_Out  = data_out_q;
    assign Valid_Out = valid_out_q;

endmodule

// File: tb/tb_pointwise_conv_tmux.sv
// -----------------------------------------------------------------------------
// tb_pointwise_conv_tmux
//   Self-checking bench for pointwise_conv_tmux with IN_CH=4, OUT_CH=2.
//   Stimulus pushes expected results into a queue; a monitor on the falling
//   edge pops and compares on every new Valid_Out and checks latency and
//   back-to-back spacing.
// -----------------------------------------------------------------------------
module tb_pointwise_conv_tmux;
    localparam int DW     = 16;
    localparam int FB     = 8;
    localparam int IN_CH  = 4;
    localparam int OUT_CH = 2;

    logic                   clk;
    logic                   rst;
    logic [DW*IN_CH-1:0]    Data_In;
    logic                   Valid_In;
    logic                   Ready_In;
    logic [DW*OUT_CH-1:0]   Data_Out;
    logic                   Valid_Out;
    logic                   Ready_Out;
    logic                   W_We;
    logic [2:0]             W_Addr;
    logic [DW-1:0]          W_Data;

    pointwise_conv_tmux #(
        .DATA_WIDHT(DW),
        .FRAC_BITS (FB),
        .IN_CH     (IN_CH),
        .OUT_CH    (OUT_CH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .Data_In  (Data_In),
        .Valid_In (Valid_In),
        .Ready_In (Ready_In),
        .Data_Out (Data_Out),
        .Valid_Out(Valid_Out),
        .Ready_Out(Ready_Out),
        .W_We     (W_We),
        .W_Addr   (W_Addr),
        .W_Data   (W_Data)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] expq [$];
    int          accq [$];
    bit          acc_pend = 1'b0;
    bit          prev_v   = 1'b0;
    bit          b2b      = 1'b0;
    int          last_res = -1;

    logic signed [DW-1:0] wm [OUT_CH][IN_CH];
    logic [63:0]          px [8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [63:0] pack4(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c, input logic [15:0] d);
        return {d, c, b, a};
    endfunction

    // Reference dot product with per-product truncation and output saturation.
    function automatic logic [31:0] model(input logic [63:0] p);
        logic [31:0]          r;
        longint               acc;
        longint               prod;
        logic signed [DW-1:0] xs;
        logic signed [DW-1:0] ws;
        r = '0;
        for (int o = 0; o < OUT_CH; o++) begin
            acc = 0;
            for (int i = 0; i < IN_CH; i++) begin
                xs   = p[i*DW +: DW];
                ws   = wm[o][i];
                prod = longint'(xs) * longint'(ws);
                acc  = acc + (prod >>> FB);
            end
            if (acc > 32767) acc = 32767;
            else if (acc < -32768) acc = -32768;
`ifdef PWCONV_RELU_EN
            if (acc < 0) acc = 0;
`endif
            r[o*DW +: DW] = acc[15:0];
        end
        return r;
    endfunction

    // Monitor: track accepted pixels and score every new result.
    always @(negedge clk) begin
        logic [31:0] e;
        int          a;
        if (!rst) begin
            accq.delete();
            acc_pend = 1'b0;
            prev_v   = 1'b0;
        end else begin
            if (acc_pend) accq.push_back(cyc);
            acc_pend = Valid_In && Ready_In;
            if (Valid_Out && !prev_v) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %h with no result pending", Data_Out);
                end else begin
                    e = expq.pop_front();
                    chk("data_out", {32'd0, Data_Out}, {32'd0, e});
                end
                if (accq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL latency: result with no accepted pixel recorded");
                end else begin
                    a = accq.pop_front();
                    chk("latency", 64'(cyc - a), 64'(IN_CH));
                end
                if (b2b && last_res >= 0) chk("spacing", 64'(cyc - last_res), 64'(IN_CH + 1));
                last_res = cyc;
            end
            prev_v = Valid_Out;
        end
    end

    task automatic wr(input int a, input logic [15:0] d);
        W_We   = 1'b1;
        W_Addr = 3'(a);
        W_Data = d;
        @(posedge clk); #1;
        W_We = 1'b0;
        wm[a / IN_CH][a % IN_CH] = d;
    endtask

    task automatic send(input logic [63:0] p, input logic [31:0] exp, input bit push, output int tries);
        bit got;
        got      = 1'b0;
        tries    = 0;
        Valid_In = 1'b1;
        Data_In  = p;
        while (!got && tries < 200) begin
            @(negedge clk);
            got = Ready_In;
            tries++;
            @(posedge clk); #1;
        end
        Valid_In = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: pixel %h not accepted", p);
        end
        if (push) expq.push_back(exp);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (expq.size() != 0 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: %0d results outstanding", expq.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b0; Valid_In = 1'b0; Data_In = '0; Ready_Out = 1'b1;
        W_We = 1'b0; W_Addr = '0; W_Data = '0;
        for (int o = 0; o < OUT_CH; o++)
            for (int i = 0; i < IN_CH; i++) wm[o][i] = '0;
        px[0] = pack4(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        px[1] = pack4(16'h0200, 16'h0000, 16'h0000, 16'h0000);
        px[2] = pack4(16'hFF00, 16'h0300, 16'h0080, 16'h0100);
        px[3] = pack4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        px[4] = pack4(16'h8000, 16'h0000, 16'h0000, 16'h8000);
        px[5] = pack4(16'h0010, 16'h0020, 16'h0030, 16'h0040);
        px[6] = pack4(16'h1234, 16'hEDCB, 16'h0F0F, 16'hF0F0);
        px[7] = pack4(16'h0000, 16'h0000, 16'h0000, 16'h0001);

        // Reset state
        #2;
        chk("rst_valid_out", {63'd0, Valid_Out}, 64'd0);
        chk("rst_data_out", {32'd0, Data_Out}, 64'd0);
        chk("rst_ready_in", {63'd0, Ready_In}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Identity weights
        wr(0, 16'h0100);
        wr(5, 16'h0100);
        send(pack4(16'h0100, 16'h0200, 16'h0300, 16'h0400), 32'h0200_0100, 1'b1, t);
        wait_done();

        // Stall in HOLD, then consume and accept in the same cycle
        Ready_Out = 1'b0;
        send(pack4(16'h0180, 16'h0280, 16'h7000, 16'h1111), 32'h0280_0180, 1'b1, t);
        t = 0;
        while (!Valid_Out && t < 50) begin @(posedge clk); #1; t++; end
        Valid_In = 1'b1;
        Data_In  = pack4(16'h0040, 16'h0080, 16'h1000, 16'h2000);
        for (int k = 0; k < 10; k++) begin
            chk("stall_valid_out", {63'd0, Valid_Out}, 64'd1);
            chk("stall_ready_in", {63'd0, Ready_In}, 64'd0);
            chk("stall_data_out", {32'd0, Data_Out}, 64'h0000_0000_0280_0180);
            @(posedge clk); #1;
        end
        Ready_Out = 1'b1;
        send(pack4(16'h0040, 16'h0080, 16'h1000, 16'h2000), 32'h0080_0040, 1'b1, t);
        chk("hold_accept_tries", 64'(t), 64'd1);
        wait_done();

        // Weight write during ACCUM is ignored
        send(pack4(16'h0100, 16'h0100, 16'h0000, 16'h0000), 32'h0100_0100, 1'b1, t);
        W_We = 1'b1; W_Addr = 3'd0; W_Data = 16'h1234;
        @(posedge clk); #1;
        W_We = 1'b0;
        wait_done();
        send(pack4(16'h0100, 16'h0100, 16'h0000, 16'h0000), 32'h0100_0100, 1'b1, t);
        wait_done();

        // Same write in IDLE takes effect for the next pixel
        wr(0, 16'h1234);
        send(pack4(16'h0100, 16'h0100, 16'h0000, 16'h0000), 32'h0100_1234, 1'b1, t);
        wait_done();

        // Write coinciding with acceptance: pixel sees old weight, next sees new
        W_We = 1'b1; W_Addr = 3'd5; W_Data = 16'h0200;
        send(pack4(16'h0100, 16'h0100, 16'h0000, 16'h0000), 32'h0100_1234, 1'b1, t);
        W_We = 1'b0;
        wm[1][1] = 16'h0200;
        wait_done();
        send(pack4(16'h0100, 16'h0100, 16'h0000, 16'h0000), 32'h0200_1234, 1'b1, t);
        wait_done();

        // Reset mid-ACCUM at cnt=2
        send(pack4(16'h0100, 16'h0100, 16'h0100, 16'h0100), 32'h0, 1'b0, t);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_valid_out", {63'd0, Valid_Out}, 64'd0);
        chk("midrst_ready_in", {63'd0, Ready_In}, 64'd1);
        chk("midrst_data_out", {32'd0, Data_Out}, 64'd0);
        for (int o = 0; o < OUT_CH; o++)
            for (int i = 0; i < IN_CH; i++) wm[o][i] = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        send(pack4(16'h0100, 16'h0200, 16'h0300, 16'h0400), 32'h0000_0000, 1'b1, t);
        wait_done();

        // Back-to-back pixels against the reference model
        wr(0, 16'h0100); wr(1, 16'hFF80); wr(2, 16'h0200); wr(3, 16'h0040);
        wr(4, 16'hFE00); wr(5, 16'h0180); wr(6, 16'h0000); wr(7, 16'h7FFF);
        b2b      = 1'b1;
        last_res = -1;
        for (int j = 0; j < 8; j++) send(px[j], model(px[j]), 1'b1, t);
        wait_done();
        b2b = 1'b0;

        // Saturation
        for (int a = 0; a < 8; a++) wr(a, 16'h7FFF);
        send(pack4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), 32'h7FFF_7FFF, 1'b1, t);
        wait_done();
`ifdef PWCONV_RELU_EN
        send(pack4(16'h8000, 16'h8000, 16'h8000, 16'h8000), 32'h0000_0000, 1'b1, t);
`else
        send(pack4(16'h8000, 16'h8000, 16'h8000, 16'h8000), 32'h8000_8000, 1'b1, t);
`endif
        wait_done();

        chk("queue_drained", 64'(expq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
